interface_skid_fifo: RTL and testbench

//  Parametrised elastic buffer for valid/ready channels between cache pipeline stages.

---
 rtl/interface_skid_fifo_pkg.sv | 19 +
 rtl/interface_skid_mem.sv | 30 +++
 rtl/interface_skid_fifo.sv | 93 +++++++++
 tb/tb_interface_skid_fifo.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/interface_skid_fifo_pkg.sv
// Shared definitions for interface_skid_fifo: default sizes, count/pointer types and
// the pointer-increment helper that wraps at DEPTH-1 for any depth.
package interface_skid_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 2;
    localparam int DEF_CNT_W      = $clog2(DEF_DEPTH + 1);
    localparam int DEF_PTR_W      = (DEF_DEPTH > 1) ? $clog2(DEF_DEPTH) : 1;

    typedef logic [DEF_CNT_W-1:0] cnt_t;
    typedef logic [DEF_PTR_W-1:0] ptr_t;

    // Explicit wrap so non-power-of-two depths never visit unused slots.
    function automatic int unsigned ptr_wrap_inc(input int unsigned ptr,
                                                 input int unsigned depth);
        return (ptr >= depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/interface_skid_mem.sv
// Payload storage for interface_skid_fifo: DEPTH x DATA_WIDTH registers, one write
// port and one asynchronous read port. Payload is deliberately not reset.
module interface_skid_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int ADDR_W     = 1
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == ADDR_W'(gi))) begin
                    r_mem[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = r_mem[raddr];

endmodule

// File: rtl/interface_skid_fifo.sv
// Elastic valid/ready buffer with ready_out decoupled from ready_in.
// Define INTF_SKID_REG_OUT_EN for registered-output mode (no in->out combinational path).
module interface_skid_fifo
    import interface_skid_fifo_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int DEPTH      = DEF_DEPTH,
    localparam int CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_in,
    output logic [CNT_W-1:0]      count,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] w_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_enq;
    logic                  w_deq;
    logic                  w_store;
    logic                  w_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign ready_out = !w_full && !flush;
    assign w_enq     = valid_in && ready_out;

`ifdef INTF_SKID_REG_OUT_EN
    assign valid_out = !w_empty && !flush;
    assign data_out  = w_empty ? '0 : w_rdata;
    assign w_store   = w_enq;
`else
    // When empty the beat is offered downstream directly and only stored if refused.
    assign valid_out = (w_empty ? valid_in : 1'b1) && !flush;
    assign data_out  = w_empty ? data_in : w_rdata;
    assign w_store   = w_enq && !(w_empty && ready_in);
`endif

    assign w_deq = valid_out && ready_in;
    assign w_pop = w_deq && !w_empty;

    interface_skid_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (w_store),
        .waddr (r_tail),
        .wdata (data_in),
        .raddr (r_head),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_store) begin
                r_tail <= PTR_W'(ptr_wrap_inc(32'(r_tail), DEPTH));
            end
            if (w_pop) begin
                r_head <= PTR_W'(ptr_wrap_inc(32'(r_head), DEPTH));
            end
            r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_pop);
        end
    end

    assign count = r_count;
    assign full  = w_full;
    assign empty = w_empty;

endmodule

// File: tb/tb_interface_skid_fifo.sv
// Directed bench for interface_skid_fifo (cut-through build): DEPTH=2 and DEPTH=3 instances.
module tb_interface_skid_fifo;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        f2 = 1'b0, v2 = 1'b0, r2 = 1'b0;
    logic [31:0] d2 = '0;
    logic        ro2, vo2, full2, empty2;
    logic [31:0] do2;
    logic [1:0]  cnt2;

    logic        f3 = 1'b0, v3 = 1'b0, r3 = 1'b0;
    logic [31:0] d3 = '0;
    logic        ro3, vo3, full3, empty3;
    logic [31:0] do3;
    logic [1:0]  cnt3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    interface_skid_fifo #(.DATA_WIDTH(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst(rst), .flush(f2), .valid_in(v2), .data_in(d2),
        .ready_out(ro2), .valid_out(vo2), .data_out(do2), .ready_in(r2),
        .count(cnt2), .full(full2), .empty(empty2)
    );

    interface_skid_fifo #(.DATA_WIDTH(32), .DEPTH(3)) dut3 (
        .clk(clk), .rst(rst), .flush(f3), .valid_in(v3), .data_in(d3),
        .ready_out(ro3), .valid_out(vo3), .data_out(do3), .ready_in(r3),
        .count(cnt3), .full(full3), .empty(empty3)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", tag, act);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step3(input logic v, input logic [31:0] d, input logic r,
                         input logic evo, input logic [31:0] edo,
                         input logic [1:0] ecnt, input logic ero, input string tag);
        v3 = v; d3 = d; r3 = r;
        #1;
        check_val({tag, " vo"},  32'(vo3),  32'(evo));
        check_val({tag, " do"},  do3,       edo);
        check_val({tag, " cnt"}, 32'(cnt3), 32'(ecnt));
        check_val({tag, " ro"},  32'(ro3),  32'(ero));
        tick();
    endtask

    initial begin
        // Reset state
        #2;
        check_val("rst cnt",   32'(cnt2),   32'd0);
        check_val("rst empty", 32'(empty2), 32'd1);
        check_val("rst full",  32'(full2),  32'd0);
        check_val("rst vo",    32'(vo2),    32'd0);
        check_val("rst ro",    32'(ro2),    32'd1);
        check_val("rst do",    do2,         32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // 1: streaming pass-through
        r2 = 1'b1; v2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d2 = 32'h10 + 32'(i);
            #1;
            check_val("t1 vo",  32'(vo2),  32'd1);
            check_val("t1 do",  do2,       32'h10 + 32'(i));
            check_val("t1 cnt", 32'(cnt2), 32'd0);
            check_val("t1 ro",  32'(ro2),  32'd1);
            tick();
        end
        v2 = 1'b0; d2 = '0;
        tick();

        // 2: stall, fill, hold while full, drain in order
        r2 = 1'b0; v2 = 1'b1; d2 = 32'hA;
        #1; check_val("t2 cnt0", 32'(cnt2), 32'd0);
        tick();
        d2 = 32'hB;
        #1; check_val("t2 cnt1", 32'(cnt2), 32'd1);
        check_val("t2 do A", do2, 32'hA);
        check_val("t2 ro1",  32'(ro2), 32'd1);
        tick();
        d2 = 32'hC;
        #1; check_val("t2 cnt2", 32'(cnt2), 32'd2);
        check_val("t2 full", 32'(full2), 32'd1);
        check_val("t2 ro0",  32'(ro2),   32'd0);
        tick();
        #1; check_val("t2 held cnt", 32'(cnt2), 32'd2);
        check_val("t2 held do", do2, 32'hA);
        r2 = 1'b1;
        #1; check_val("t2 out A", do2, 32'hA);
        check_val("t2 out A vo", 32'(vo2), 32'd1);
        tick();
        #1; check_val("t2 out B", do2, 32'hB);
        check_val("t2 cnt after A", 32'(cnt2), 32'd1);
        tick();
        v2 = 1'b0; d2 = '0;
        #1; check_val("t2 out C", do2, 32'hC);
        check_val("t2 cnt after B", 32'(cnt2), 32'd1);
        tick();
        #1; check_val("t2 drained cnt", 32'(cnt2), 32'd0);
        check_val("t2 drained vo", 32'(vo2), 32'd0);
        tick();

        // 3: simultaneous enq/deq at count=1
        r2 = 1'b0; v2 = 1'b1; d2 = 32'h4;
        tick();
        r2 = 1'b1; d2 = 32'h5;
        #1; check_val("t3 do 4", do2, 32'h4);
        check_val("t3 cnt1", 32'(cnt2), 32'd1);
        tick();
        v2 = 1'b0; d2 = '0;
        #1; check_val("t3 cnt kept", 32'(cnt2), 32'd1);
        check_val("t3 do 5", do2, 32'h5);
        tick();
        #1; check_val("t3 empty", 32'(empty2), 32'd1);
        tick();

        // 4: DEPTH=3 pointer wrap with stalls
        rst = 1'b1;
        step3(1'b1, 32'h50, 1'b0, 1'b1, 32'h50, 2'd0, 1'b1, "t4 c0");
        step3(1'b1, 32'h51, 1'b0, 1'b1, 32'h50, 2'd1, 1'b1, "t4 c1");
        step3(1'b1, 32'h52, 1'b1, 1'b1, 32'h50, 2'd2, 1'b1, "t4 c2");
        step3(1'b1, 32'h53, 1'b1, 1'b1, 32'h51, 2'd2, 1'b1, "t4 c3");
        step3(1'b1, 32'h54, 1'b0, 1'b1, 32'h52, 2'd2, 1'b1, "t4 c4");
        step3(1'b1, 32'h55, 1'b1, 1'b1, 32'h52, 2'd3, 1'b0, "t4 c5");
        step3(1'b1, 32'h55, 1'b1, 1'b1, 32'h53, 2'd2, 1'b1, "t4 c6");
        step3(1'b0, 32'h0,  1'b1, 1'b1, 32'h54, 2'd2, 1'b1, "t4 c7");
        step3(1'b0, 32'h0,  1'b1, 1'b1, 32'h55, 2'd1, 1'b1, "t4 c8");
        step3(1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  2'd0, 1'b1, "t4 c9");

        // 5: flush with count=2 and valid_in asserted
        r2 = 1'b0; v2 = 1'b1; d2 = 32'h20;
        tick();
        d2 = 32'h21;
        tick();
        f2 = 1'b1; d2 = 32'h22;
        #1; check_val("t5 cnt pre", 32'(cnt2), 32'd2);
        check_val("t5 vo", 32'(vo2), 32'd0);
        check_val("t5 ro", 32'(ro2), 32'd0);
        tick();
        f2 = 1'b0; v2 = 1'b0; d2 = '0; r2 = 1'b1;
        #1; check_val("t5 cnt", 32'(cnt2), 32'd0);
        check_val("t5 empty", 32'(empty2), 32'd1);
        check_val("t5 vo after", 32'(vo2), 32'd0);
        tick();
        v2 = 1'b1; d2 = 32'h30;
        #1; check_val("t5 fresh do", do2, 32'h30);
        tick();
        v2 = 1'b0; d2 = '0;
        #1; check_val("t5 no stale vo", 32'(vo2), 32'd0);
        tick();

        // 6: asynchronous reset with count=2
        r2 = 1'b0; v2 = 1'b1; d2 = 32'h40;
        tick();
        d2 = 32'h41;
        tick();
        v2 = 1'b0; d2 = '0;
        #1; check_val("t6 cnt pre", 32'(cnt2), 32'd2);
        #1; rst = 1'b0;
        #1; check_val("t6 cnt", 32'(cnt2), 32'd0);
        check_val("t6 vo", 32'(vo2), 32'd0);
        check_val("t6 ro", 32'(ro2), 32'd1);
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
